// File: rtl/multich_boxcar_integrator_if.sv
// Sample stream in, window results out, for the multichannel boxcar integrator.
// The master drives samples and observes results; the slave is the integrator.
interface multich_boxcar_integrator_if #(
   parameter int DAT_BITS = 16,
   parameter int CNT_BITS = 16,
   parameter int N_CH     = 2
);
   localparam int ACC_BITS = DAT_BITS + CNT_BITS;

   logic [N_CH*DAT_BITS-1:0] in_data;
   logic                     in_valid;
   logic [N_CH*ACC_BITS-1:0] sum_out;
   logic [CNT_BITS-1:0]      cnt_out;
   logic                     out_valid;

   modport master (
      output in_data,
      output in_valid,
      input  sum_out,
      input  cnt_out,
      input  out_valid
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output sum_out,
      output cnt_out,
      output out_valid
   );
endinterface

// File: rtl/multich_boxcar_integrator.sv
// N_CH parallel boxcar integrators sharing one window length/sync timing,
// emitting a raw or arithmetically shifted window sum with a one-cycle strobe.
module multich_boxcar_integrator #(
   parameter int DAT_BITS = 16,
   parameter int CNT_BITS = 16,
   parameter int N_CH     = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_enable,
   input  logic                i_sync,
   input  logic [CNT_BITS-1:0] i_win_len,
   input  logic                i_avg_mode,
   input  logic [4:0]          i_avg_shift,
   output logic                o_busy,
   multich_boxcar_integrator_if.slave bus
);
   localparam int ACC_BITS = DAT_BITS + CNT_BITS;
   localparam logic [31:0] SHIFT_MAX = 32'(CNT_BITS);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   state_t                   r_state;
   logic [ACC_BITS-1:0]      r_acc [N_CH];
   logic [CNT_BITS-1:0]      r_count;
   logic [CNT_BITS-1:0]      r_len;
   logic [N_CH*ACC_BITS-1:0] r_sum;
   logic [CNT_BITS-1:0]      r_cnt_out;
   logic                     r_out_valid;
   logic                     r_busy;

   logic                     w_accept;
   logic                     w_count_nz;
   logic                     w_early;
   logic                     w_first;
   logic                     w_full;
   logic                     w_emit;
   logic                     w_clear;
   logic [CNT_BITS-1:0]      w_len_new;
   logic [CNT_BITS-1:0]      w_len_eff;
   logic [CNT_BITS-1:0]      w_base_count;
   logic [CNT_BITS-1:0]      w_count_inc;
   logic [CNT_BITS-1:0]      w_nxt_count;
   logic [CNT_BITS-1:0]      w_nxt_len;
   logic [CNT_BITS-1:0]      w_emit_cnt;
   logic [4:0]               w_shamt;
   logic [ACC_BITS-1:0]      w_base_acc [N_CH];
   logic [ACC_BITS-1:0]      w_sum [N_CH];
   logic [ACC_BITS-1:0]      w_nxt_acc [N_CH];
   logic [N_CH*ACC_BITS-1:0] w_emit_sum;

   function automatic logic [ACC_BITS-1:0] f_sext(input logic [DAT_BITS-1:0] d);
      f_sext = {{CNT_BITS{d[DAT_BITS-1]}}, d};
   endfunction

   function automatic logic [ACC_BITS-1:0] f_avg(input logic [ACC_BITS-1:0] v,
                                                 input logic mode,
                                                 input logic [4:0] shamt);
      if (mode) begin
         f_avg = ACC_BITS'($signed(v) >>> shamt);
      end else begin
         f_avg = v;
      end
   endfunction

   // Window control: decides acceptance, start of a new window, and closure.
   always_comb begin
      w_accept   = i_enable & bus.in_valid;
      w_count_nz = (r_count != '0);
      // r_count == r_len only arises when a length-1 window was opened on a sync edge
      w_early    = i_enable & w_count_nz & (i_sync | (r_count == r_len));
      w_first    = w_early | ~w_count_nz;
      if (i_win_len == '0) begin
         w_len_new = CNT_BITS'(1);
      end else begin
         w_len_new = i_win_len;
      end
      if (w_first) begin
         w_len_eff    = w_len_new;
         w_base_count = '0;
      end else begin
         w_len_eff    = r_len;
         w_base_count = r_count;
      end
      w_count_inc = w_base_count + CNT_BITS'(1);
      w_full      = w_accept & (w_count_inc == w_len_eff);
      w_emit      = w_early | w_full;
      w_clear     = w_full & ~w_early;
      if (!i_enable) begin
         w_nxt_count = '0;
      end else if (w_accept) begin
         w_nxt_count = w_clear ? '0 : w_count_inc;
      end else begin
         w_nxt_count = w_base_count;
      end
      if (w_accept && w_first) begin
         w_nxt_len = w_len_new;
      end else begin
         w_nxt_len = r_len;
      end
      if (w_early) begin
         w_emit_cnt = r_count;
      end else begin
         w_emit_cnt = w_len_eff;
      end
      if ({27'd0, i_avg_shift} > SHIFT_MAX) begin
         w_shamt = SHIFT_MAX[4:0];
      end else begin
         w_shamt = i_avg_shift;
      end
   end

   // Per-channel accumulate and result selection.
   always_comb begin
      w_emit_sum = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_base_acc[c] = w_first ? '0 : r_acc[c];
         w_sum[c]      = w_base_acc[c] + f_sext(bus.in_data[c*DAT_BITS +: DAT_BITS]);
         if (!i_enable) begin
            w_nxt_acc[c] = '0;
         end else if (w_accept) begin
            w_nxt_acc[c] = w_clear ? '0 : w_sum[c];
         end else begin
            w_nxt_acc[c] = w_base_acc[c];
         end
         if (w_early) begin
            w_emit_sum[c*ACC_BITS +: ACC_BITS] = f_avg(r_acc[c], i_avg_mode, w_shamt);
         end else begin
            w_emit_sum[c*ACC_BITS +: ACC_BITS] = f_avg(w_sum[c], i_avg_mode, w_shamt);
         end
      end
   end

   // State, accumulators and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         for (int c = 0; c < N_CH; c++) begin
            r_acc[c] <= '0;
         end
         r_count     <= '0;
         r_len       <= CNT_BITS'(1);
         r_sum       <= '0;
         r_cnt_out   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= i_enable ? ST_ACC : ST_IDLE;
            ST_ACC:  r_state <= i_enable ? ST_ACC : ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         for (int c = 0; c < N_CH; c++) begin
            r_acc[c] <= w_nxt_acc[c];
         end
         r_count     <= w_nxt_count;
         r_len       <= w_nxt_len;
         r_busy      <= (w_nxt_count != '0);
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_sum     <= w_emit_sum;
            r_cnt_out <= w_emit_cnt;
         end
      end
   end

   assign bus.sum_out   = r_sum;
   assign bus.cnt_out   = r_cnt_out;
   assign bus.out_valid = r_out_valid;
   assign o_busy        = r_busy;
endmodule
